pattern_detect_ctrl: RTL and testbench

PATTERN_DETECT_CTRL -- requirements
Module: pattern_detect_ctrl

---
 rtl/pattern_detect_pkg.sv | 13 +
 rtl/pattern_match_core.sv | 54 +++++
 rtl/pattern_detect_ctrl.sv | 107 ++++++++++
 tb/tb_pattern_detect_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_detect_pkg.sv
// Shared types and defaults for the serial pattern detector.
package pattern_detect_pkg;

  localparam int unsigned DEF_PAT_W = 8;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_match_core.sv
// History shift register, fill counter and masked comparator for the detector.
module pattern_match_core
  import pattern_detect_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       step,
  input  logic                       x,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [$clog2(PAT_W)-1:0]   len,
  input  logic                       overlap,
  output logic                       match
);

  localparam int unsigned LW = $clog2(PAT_W);

  logic [PAT_W-2:0] history;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic [LW-1:0]    fill;

  assign window = {history, x};

  // Only bits [len:0] of the window take part in the compare.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      if (LW'(i) <= len) mask[i] = 1'b1;
    end
  end

  assign match = step && (fill >= len) && (((window ^ pattern) & mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (step) begin
      history <= window[PAT_W-2:0];
      if (match && !overlap) begin
        fill <= '0;
      end else if (fill < len) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Configurable serial pattern detector: config handshake, run FSM and match counter.
module pattern_detect_ctrl
  import pattern_detect_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W)-1:0]   cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       en,
  input  logic                       x_valid,
  input  logic                       x,
  output logic                       z,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [1:0]                 state_o
);

  state_t                     state, state_nxt;
  logic                       run;
  logic                       hs;
  logic                       leave_run;
  logic                       step;
  logic                       core_match;
  logic [PAT_W-1:0]           pattern_q;
  logic [$clog2(PAT_W)-1:0]   len_q;
  logic                       overlap_q;
  logic [CNT_W-1:0]           cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A handshake in ARMED takes priority over en, so a fresh config always lands in ARMED.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = ARMED;
      ARMED:   if (hs) state_nxt = ARMED;
               else if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b1;
    run       = 1'b0;
    unique case (state)
      IDLE:    cfg_ready = 1'b1;
      ARMED:   cfg_ready = 1'b1;
      RUN:     begin cfg_ready = 1'b0; run = 1'b1; end
      default: cfg_ready = 1'b1;
    endcase
  end

  assign hs        = cfg_valid & cfg_ready;
  assign leave_run = run & ~en;
  assign step      = run & x_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
    end else if (hs) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
    end
  end

  pattern_match_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (hs | leave_run),
    .step    (step),
    .x       (x),
    .pattern (pattern_q),
    .len     (len_q),
    .overlap (overlap_q),
    .match   (core_match)
  );

  assign z = core_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (hs) begin
      cnt_q <= '0;
    end else if (z && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
  assign state_o   = state;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Bench for pattern_detect_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_pattern_detect_ctrl;

  localparam int unsigned PW = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic [2:0]   cfg_len = '0;
  logic         cfg_overlap = 1'b0;
  logic         en = 1'b0;
  logic         x_valid = 1'b0;
  logic         x = 1'b0;

  logic         cfg_ready, z;
  logic [7:0]   match_cnt;
  logic [1:0]   state_o;
  logic         cfg_ready_s, z_s;
  logic [1:0]   match_cnt_s;
  logic [1:0]   state_s;

  pattern_detect_ctrl #(.PAT_W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .en(en), .x_valid(x_valid), .x(x), .z(z), .match_cnt(match_cnt), .state_o(state_o)
  );

  pattern_detect_ctrl #(.PAT_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .en(en), .x_valid(x_valid), .x(x), .z(z_s), .match_cnt(match_cnt_s), .state_o(state_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 armed, 2 run; q holds accepted bits usable for the next match.
  int         m_state;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt, m_cnts;
  bit         q[$];

  int vidx;
  int hits[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_z(input bit xv, input bit xb);
    if (m_state != 2 || !xv) return 1'b0;
    if (q.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (q[q.size() - m_len + k] != m_pat[m_len - k]) return 1'b0;
    return xb == m_pat[0];
  endfunction

  task automatic model_reset();
    m_state = 0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
    m_cnt = 0; m_cnts = 0; q.delete();
  endtask

  task automatic step(input bit cv, input logic [7:0] pat, input int len, input bit ovl,
                      input bit e, input bit xv, input bit xb);
    bit ez, hs;
    @(negedge clk);
    cfg_valid = cv; cfg_pattern = pat; cfg_len = 3'(len); cfg_overlap = ovl;
    en = e; x_valid = xv; x = xb;
    #1;
    ez = model_z(xv, xb);
    check("z", z, ez);
    check("z_sat", z_s, ez);
    check("cfg_ready", cfg_ready, m_state != 2);
    check("state", state_o, m_state);
    check("state_sat", state_s, m_state);
    if (xv) begin
      vidx++;
      if (z === 1'b1) hits.push_back(vidx);
    end
    @(posedge clk);
    hs = cv && (m_state != 2);
    if (hs) begin
      m_pat = pat; m_len = len; m_ovl = ovl;
      m_cnt = 0; m_cnts = 0; q.delete(); m_state = 1;
    end else if (m_state == 1) begin
      if (e) m_state = 2;
    end else if (m_state == 2) begin
      if (xv) begin
        q.push_back(xb);
        if (q.size() > PW) void'(q.pop_front());
      end
      if (ez) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnts < 3) m_cnts++;
        if (!m_ovl) q.delete();
      end
      if (!e) begin m_state = 1; q.delete(); end
    end
    #1;
    check("match_cnt", match_cnt, m_cnt);
    check("match_cnt_sat", match_cnt_s, m_cnts);
  endtask

  task automatic cfg(input logic [7:0] pat, input int len, input bit ovl);
    step(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic run_on();   step(1'b0, '0, 0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic run_off();  step(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic bit_in(input bit b); step(1'b0, '0, 0, 1'b0, 1'b1, 1'b1, b); endtask
  task automatic bubble();   step(1'b0, '0, 0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic clear_hits(); vidx = 0; hits.delete(); endtask

  bit s34[15] = '{1,1,0,1,1,1,1,0,0,1,0,1,1,1,1};
  bit s35[5]  = '{1,0,1,0,1};
  int sat_exp[6] = '{1,2,3,3,3,3};
  bit s39[5]  = '{1,0,1,1,1};

  initial begin
    bit cur_en;
    bit cv, xv, xb;
    int len;
    logic [7:0] pat;

    model_reset();
    #2;
    check("rst_state", state_o, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_z", z, 0);
    check("rst_cnt", match_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Non-overlapping detection of 101111.
    cfg(8'b0010_1111, 5, 1'b0);
    run_on();
    clear_hits();
    foreach (s34[i]) bit_in(s34[i]);
    check("no_ovl_hits", hits.size(), 2);
    if (hits.size() == 2) begin
      check("no_ovl_hit0", hits[0], 7);
      check("no_ovl_hit1", hits[1], 15);
    end
    check("no_ovl_cnt", match_cnt, 2);

    // Same stream with x_valid bubbles.
    run_off();
    cfg(8'b0010_1111, 5, 1'b0);
    run_on();
    clear_hits();
    foreach (s34[i]) begin
      repeat ($urandom_range(0, 2)) bubble();
      bit_in(s34[i]);
    end
    check("gap_hits", hits.size(), 2);
    if (hits.size() == 2) begin
      check("gap_hit0", hits[0], 7);
      check("gap_hit1", hits[1], 15);
    end
    check("gap_cnt", match_cnt, 2);

    // Overlap on, then off, for 101.
    run_off();
    cfg(8'b0000_0101, 2, 1'b1);
    run_on();
    clear_hits();
    foreach (s35[i]) bit_in(s35[i]);
    check("ovl1_hits", hits.size(), 2);
    check("ovl1_cnt", match_cnt, 2);
    run_off();
    cfg(8'b0000_0101, 2, 1'b0);
    run_on();
    clear_hits();
    foreach (s35[i]) bit_in(s35[i]);
    check("ovl0_hits", hits.size(), 1);
    if (hits.size() == 1) check("ovl0_hit0", hits[0], 3);
    check("ovl0_cnt", match_cnt, 1);

    // Config offered during RUN stays pending until en drops.
    run_off();
    cfg(8'b0000_0101, 2, 1'b1);
    run_on();
    clear_hits();
    bit_in(1'b1);
    bit_in(1'b0);
    step(1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("hs_old_cfg_hit", hits.size(), 1);
    check("hs_run_ready", cfg_ready, 0);
    check("hs_run_cnt", match_cnt, 1);
    step(1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hs_armed", state_o, 1);
    step(1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hs_cnt_clr", match_cnt, 0);
    check("hs_state", state_o, 1);
    run_on();
    clear_hits();
    bit_in(1'b0);
    check("hs_new_cfg_hit", hits.size(), 1);

    // Saturation of the 2-bit counter with a 1-bit pattern.
    run_off();
    cfg(8'h01, 0, 1'b0);
    run_on();
    for (int i = 0; i < 6; i++) begin
      bit_in(1'b1);
      check("sat_seq", match_cnt_s, sat_exp[i]);
    end

    // Asynchronous reset in the middle of a partial match.
    run_off();
    cfg(8'b0010_1111, 5, 1'b0);
    run_on();
    foreach (s39[i]) bit_in(s39[i]);
    @(negedge clk);
    cfg_valid = 1'b0; en = 1'b1; x_valid = 1'b1; x = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_state", state_o, 0);
    check("mid_rst_z", z, 0);
    check("mid_rst_cnt", match_cnt, 0);
    check("mid_rst_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_hits();
    bit_in(1'b1);
    check("post_rst_nomatch", hits.size(), 0);
    check("post_rst_idle", state_o, 0);

    // Random traffic against the model.
    cur_en = 1'b0;
    for (int n = 0; n < 600; n++) begin
      cv  = ($urandom_range(0, 31) == 0);
      pat = 8'($urandom);
      len = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 7);
      if ($urandom_range(0, 19) == 0) cur_en = ~cur_en;
      if (n < 4) begin cv = 1'b1; cur_en = 1'b1; end
      xv = ($urandom_range(0, 3) != 0);
      xb = 1'($urandom);
      step(cv, pat, len, 1'($urandom), cur_en, xv, xb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
